// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: instruction fields, FSM states
// and ALU operations, plus the small ALU/extension helpers used by the datapath.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC     = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WR   = 4'd5,
    WB       = 4'd6,
    BRANCH   = 4'd7,
    JUMP     = 4'd8,
    TRAP     = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_LUI
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOR: r = ~(a | b);
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      ALU_LUI: r = {b[15:0], 16'h0000};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// r0 is hard-wired to zero; r29 comes out of reset holding the initial stack pointer.
module mips_regfile
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= (i == 29) ? SP_INIT : 32'h0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs_q[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core sharing one memory port between fetch and data.
// Every bus output is a flop computed from the next state, so outputs never glitch.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] SP_INIT    = 32'h7FFF_EFFC,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [31:0]           pc_o,
  output logic [31:0]           alu_result_o,
  output logic                  trap_o,
  output logic [31:0]           retired_o,
  output logic [3:0]            state_o
);

  // Handshake: req/we/addr/wdata are held until ready is sampled high on a rising
  // edge while req is high; that edge completes the access. Ready with req low is ignored.
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d, we_q, we_d, trap_q, trap_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_sx, imm_zx, mem_ea, next_pc, alu_b;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we, xfer, go_fetch;
  alu_op_t     alu_op;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign imm_sx = sext16(imm);
  assign imm_zx = {16'h0000, imm};
  assign mem_ea = a_q + imm_sx;
  assign xfer   = req_q & mem_ready_i;

  mips_regfile #(.SP_INIT(SP_INIT)) u_regfile (
    .clk     (clk),
    .rst_n   (reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_q;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI: alu_b = imm_sx;
      OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zx; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zx; end
      OP_LUI:  begin alu_op = ALU_LUI; alu_b = imm_zx; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;   pc_d = pc_q;         ir_d = ir_q;
    a_d = a_q;           b_d = b_q;           aluout_d = aluout_q;
    mdr_d = mdr_q;       req_d = req_q;       we_d = we_q;
    addr_d = addr_q;     wdata_d = wdata_q;   retired_d = retired_q;
    rf_we = 1'b0;        rf_waddr = rt;       rf_wdata = aluout_q;
    go_fetch = 1'b0;     next_pc = pc_q;

    case (state_q)
      FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + 32'd4;
          req_d   = 1'b0;
          state_d = DECODE;
        end else begin
          req_d = 1'b1;   // first cycle after reset raises the request here
        end
      end
      DECODE: begin
        a_d      = rf_rdata_a;
        b_d      = rf_rdata_b;
        aluout_d = pc_q + {imm_sx[29:0], 2'b00};
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: state_d = EXEC;
              FN_JR:   state_d = JUMP;
              default: state_d = TRAP;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = EXEC;
          OP_LW, OP_SW:                     state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = BRANCH;
          OP_J, OP_JAL:                     state_d = JUMP;
          default:                          state_d = TRAP;
        endcase
      end
      EXEC: begin
        aluout_d = alu_eval(alu_op, a_q, alu_b);
        state_d  = WB;
      end
      MEM_ADDR: begin
        aluout_d = mem_ea;
        if (mem_ea[1:0] != 2'b00) begin
          state_d = TRAP;
        end else begin
          state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
          req_d   = 1'b1;
          we_d    = (opcode == OP_SW);
          addr_d  = mem_ea;
          wdata_d = b_q;
        end
      end
      MEM_RD: begin
        if (xfer) begin
          mdr_d   = mem_rdata_i;
          req_d   = 1'b0;
          state_d = WB;
        end
      end
      MEM_WR: begin
        go_fetch = xfer;
      end
      WB: begin
        rf_we = 1'b1;
        if (opcode == OP_RTYPE) rf_waddr = rd;
        if (opcode == OP_LW) rf_wdata = mdr_q;
        go_fetch = 1'b1;
      end
      BRANCH: begin
        if ((opcode == OP_BEQ) == (a_q == b_q)) next_pc = aluout_q;
        go_fetch = 1'b1;
      end
      JUMP: begin
        if (opcode == OP_RTYPE) next_pc = a_q;
        else next_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
        if (opcode == OP_JAL) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc_q;
        end
        go_fetch = 1'b1;
      end
      TRAP: ;
      default: state_d = TRAP;
    endcase

    // Every retiring path funnels through here so the fetch setup lives in one place.
    if (go_fetch) begin
      pc_d      = next_pc;
      state_d   = FETCH;
      req_d     = 1'b1;
      we_d      = 1'b0;
      addr_d    = next_pc;
      retired_d = retired_q + 32'd1;
    end
    trap_d = (state_d == TRAP);
    if (trap_d) req_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      aluout_q  <= 32'h0;
      mdr_q     <= 32'h0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= RESET_PC;
      wdata_q   <= 32'h0;
      trap_q    <= 1'b0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q[ADDR_WIDTH-1:0];
  assign mem_wdata_o  = wdata_q;
  assign pc_o         = pc_q;
  assign alu_result_o = aluout_q;
  assign trap_o       = trap_q;
  assign retired_o    = retired_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small hand-assembled programs run from a
// behavioural memory with configurable wait states; results checked with assertions.
module tb_mips_multicycle_core;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] SP_INIT  = 32'h7FFF_EFFC;

  logic        clk, reset;
  logic        mem_req_o, mem_we_o, mem_ready_i, trap_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o, alu_result_o, retired_o;
  logic [3:0]  state_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wait_cycles = 0;
  int n_access = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_st_addr, last_st_data;

  mips_multicycle_core #(.RESET_PC(RESET_PC), .SP_INIT(SP_INIT), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i), .pc_o(pc_o), .alu_result_o(alu_result_o),
    .trap_o(trap_o), .retired_o(retired_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin forever begin @(posedge clk); cyc++; end end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ready_i || !reset || !mem_req_o) cnt = 0;
      mem_ready_i = 1'b0;
      if (reset && mem_req_o) begin
        if (cnt >= wait_cycles) begin
          mem_ready_i = 1'b1;
          n_access++;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            last_st_addr = mem_addr_o;
            last_st_data = mem_wdata_o;
          end else begin
            mem_rdata_i = mem_rd(mem_addr_o);
            rd_log.push_back(mem_addr_o);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    mem[RESET_PC + 32'(idx * 4)] = w;
  endtask

  task automatic enter_reset(input int wc);
    @(negedge clk);
    #2 reset = 1'b0;
    wait_cycles = wc;
    mem.delete();
    rd_log.delete();
    exp_q.delete();
    n_access = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset(input string tag, output int t0);
    @(negedge clk);
    #2 reset = 1'b1;
    check({tag, "_req_before_edge"}, {31'd0, mem_req_o}, 32'd0);
    @(posedge clk);
    #1 t0 = cyc;
    check({tag, "_req_first_edge"}, {31'd0, mem_req_o}, 32'd1);
    check({tag, "_first_addr"}, mem_addr_o, RESET_PC);
  endtask

  task automatic wait_retired(input string tag, input logic [31:0] n, output int t);
    int k;
    k = 0;
    while (retired_o !== n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (retired_o !== n) check({tag, "_timeout"}, retired_o, n);
    t = cyc;
  endtask

  task automatic check_fetches(input string tag);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_log.size() == 0) check({tag, "_missing_fetch"}, 32'hDEAD_DEAD, e);
      else check({tag, "_fetch_addr"}, rd_log.pop_front(), e);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] alu_prog [16];
  logic [31:0] alu_exp  [15];

  initial begin
    int t0, t1, t2, t3;
    logic seen_req;
    reset = 1'b0;

    // reset values
    enter_reset(0);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_trap", {31'd0, trap_o}, 32'd0);
    check("rst_retired", retired_o, 32'd0);
    check("rst_alu", alu_result_o, 32'd0);
    check("rst_state", {28'd0, state_o}, 32'd0);

    // addi/addi/add, zero wait states, then store r10
    put(0, enc_i(6'h08, 5'd0, 5'd8, 16'd5));
    put(1, enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD));
    put(2, enc_r(5'd8, 5'd9, 5'd10, 6'h20));
    put(3, enc_i(6'h2B, 5'd29, 5'd10, 16'd0));
    put(4, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    release_reset("t1", t0);
    wait_retired("t1_r1", 32'd1, t1);
    check("t1_addi_cycles", 32'(t1 - t0), 32'd4);
    check("t1_addi_alu", alu_result_o, 32'd5);
    wait_retired("t1_r2", 32'd2, t1);
    check("t1_addi_neg_alu", alu_result_o, 32'hFFFF_FFFD);
    wait_retired("t1_r3", 32'd3, t1);
    check("t1_three_instr_cycles", 32'(t1 - t0), 32'd12);
    check("t1_add_alu", alu_result_o, 32'd2);
    check("t1_pc", pc_o, RESET_PC + 32'h0C);
    wait_retired("t1_r4", 32'd4, t2);
    check("t1_sw_cycles", 32'(t2 - t1), 32'd4);
    check("t1_sw_addr", last_st_addr, SP_INIT);
    check("t1_sw_r10", last_st_data, 32'd2);

    // sw/lw pair with two wait states on every access
    enter_reset(2);
    put(0, enc_i(6'h08, 5'd0, 5'd10, 16'h1234));
    put(1, enc_i(6'h2B, 5'd29, 5'd10, 16'd0));
    put(2, enc_i(6'h23, 5'd29, 5'd11, 16'd0));
    put(3, enc_i(6'h2B, 5'd29, 5'd11, 16'd4));
    put(4, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    release_reset("t2", t0);
    wait_retired("t2_r1", 32'd1, t1);
    check("t2_addi_wait_cycles", 32'(t1 - t0), 32'd6);
    wait_retired("t2_r3", 32'd3, t3);
    check("t2_pair_cycles", 32'(t3 - t1), 32'd17);
    check("t2_mem_word", mem_rd(SP_INIT), 32'h0000_1234);
    wait_retired("t2_r4", 32'd4, t3);
    check("t2_st_addr", last_st_addr, SP_INIT + 32'd4);
    check("t2_lw_r11", last_st_data, 32'h0000_1234);

    // ALU coverage: extensions, signed slt, wrap-around, r0 discard, initial $sp
    alu_prog[0]  = enc_i(6'h0F, 5'd0, 5'd1, 16'h8000);   alu_exp[0]  = 32'h8000_0000;
    alu_prog[1]  = enc_i(6'h0D, 5'd1, 5'd1, 16'h0001);   alu_exp[1]  = 32'h8000_0001;
    alu_prog[2]  = enc_i(6'h0C, 5'd1, 5'd2, 16'hFFFF);   alu_exp[2]  = 32'h0000_0001;
    alu_prog[3]  = enc_r(5'd2, 5'd1, 5'd3, 6'h22);       alu_exp[3]  = 32'h8000_0000;
    alu_prog[4]  = enc_r(5'd1, 5'd2, 5'd4, 6'h2A);       alu_exp[4]  = 32'h0000_0001;
    alu_prog[5]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);       alu_exp[5]  = 32'h0000_0000;
    alu_prog[6]  = enc_r(5'd0, 5'd0, 5'd5, 6'h27);       alu_exp[6]  = 32'hFFFF_FFFF;
    alu_prog[7]  = enc_r(5'd1, 5'd5, 5'd6, 6'h24);       alu_exp[7]  = 32'h8000_0001;
    alu_prog[8]  = enc_r(5'd2, 5'd3, 5'd7, 6'h25);       alu_exp[8]  = 32'h8000_0001;
    alu_prog[9]  = enc_i(6'h08, 5'd5, 5'd8, 16'h0001);   alu_exp[9]  = 32'h0000_0000;
    alu_prog[10] = enc_i(6'h08, 5'd0, 5'd0, 16'h0007);   alu_exp[10] = 32'h0000_0007;
    alu_prog[11] = enc_r(5'd0, 5'd0, 5'd9, 6'h20);       alu_exp[11] = 32'h0000_0000;
    alu_prog[12] = enc_i(6'h08, 5'd5, 5'd10, 16'h8000);  alu_exp[12] = 32'hFFFF_7FFF;
    alu_prog[13] = enc_i(6'h0D, 5'd0, 5'd11, 16'h8000);  alu_exp[13] = 32'h0000_8000;
    alu_prog[14] = enc_r(5'd29, 5'd0, 5'd12, 6'h20);     alu_exp[14] = SP_INIT;
    alu_prog[15] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    enter_reset(0);
    for (int i = 0; i < 16; i++) put(i, alu_prog[i]);
    release_reset("t3", t0);
    for (int i = 0; i < 15; i++) begin
      wait_retired("t3_step", 32'(i + 1), t1);
      check($sformatf("t3_alu_%0d", i), alu_result_o, alu_exp[i]);
    end
    check("t3_total_cycles", 32'(t1 - t0), 32'd60);

    // backward beq loop (4 iterations), then bne not taken
    enter_reset(0);
    put(0, enc_i(6'h08, 5'd0, 5'd8, 16'd4));
    put(1, enc_i(6'h08, 5'd0, 5'd9, 16'd1));
    put(2, enc_i(6'h08, 5'd8, 5'd8, 16'hFFFF));
    put(3, enc_r(5'd0, 5'd8, 5'd10, 6'h2A));
    put(4, enc_i(6'h04, 5'd10, 5'd9, 16'hFFFD));
    put(5, enc_i(6'h05, 5'd8, 5'd0, 16'd5));
    put(6, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    exp_q.push_back(RESET_PC);
    exp_q.push_back(RESET_PC + 32'h04);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(RESET_PC + 32'h08);
      exp_q.push_back(RESET_PC + 32'h0C);
      exp_q.push_back(RESET_PC + 32'h10);
    end
    exp_q.push_back(RESET_PC + 32'h14);
    exp_q.push_back(RESET_PC + 32'h18);
    release_reset("t4", t0);
    wait_retired("t4_r4", 32'd4, t1);
    wait_retired("t4_r5", 32'd5, t2);
    check("t4_beq_taken_cycles", 32'(t2 - t1), 32'd3);
    wait_retired("t4_r14", 32'd14, t1);
    wait_retired("t4_r15", 32'd15, t2);
    check("t4_bne_cycles", 32'(t2 - t1), 32'd3);
    check("t4_total_cycles", 32'(t2 - t0), 32'd55);
    check("t4_pc_after_bne", pc_o, RESET_PC + 32'h18);
    wait_retired("t4_r16", 32'd16, t3);
    check_fetches("t4");

    // jal to 0x00400100, jr r31 back, then store r31
    enter_reset(0);
    put(0, enc_j(6'h03, 32'h0040_0100));
    put(1, enc_i(6'h08, 5'd0, 5'd12, 16'h0055));
    put(2, enc_i(6'h2B, 5'd29, 5'd31, 16'd0));
    put(3, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    put(64, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    exp_q.push_back(RESET_PC);
    exp_q.push_back(32'h0040_0100);
    exp_q.push_back(RESET_PC + 32'h04);
    exp_q.push_back(RESET_PC + 32'h08);
    exp_q.push_back(RESET_PC + 32'h0C);
    release_reset("t5", t0);
    wait_retired("t5_r1", 32'd1, t1);
    check("t5_jal_cycles", 32'(t1 - t0), 32'd3);
    check("t5_jal_pc", pc_o, 32'h0040_0100);
    wait_retired("t5_r2", 32'd2, t2);
    check("t5_jr_cycles", 32'(t2 - t1), 32'd3);
    check("t5_jr_pc", pc_o, RESET_PC + 32'h04);
    wait_retired("t5_r3", 32'd3, t1);
    check("t5_addi_alu", alu_result_o, 32'h0000_0055);
    wait_retired("t5_r4", 32'd4, t1);
    check("t5_r31", last_st_data, RESET_PC + 32'h04);
    wait_retired("t5_r5", 32'd5, t1);
    check_fetches("t5");

    // undefined opcode 6'h3F traps after one good instruction
    enter_reset(0);
    put(0, enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    put(1, 32'hFC00_0000);
    release_reset("t6", t0);
    wait_retired("t6_r1", 32'd1, t1);
    check("t6_trap_before", {31'd0, trap_o}, 32'd0);
    repeat (4) @(negedge clk);
    seen_req = 1'b0;
    repeat (10) begin @(negedge clk); seen_req |= mem_req_o; end
    check("t6_trap", {31'd0, trap_o}, 32'd1);
    check("t6_req_quiet", {31'd0, seen_req}, 32'd0);
    check("t6_retired", retired_o, 32'd1);
    check("t6_state", {28'd0, state_o}, 32'd9);

    // lw with offset 2 is misaligned and traps with no data access
    enter_reset(0);
    put(0, enc_i(6'h23, 5'd29, 5'd9, 16'd2));
    release_reset("t7", t0);
    repeat (4) @(negedge clk);
    seen_req = 1'b0;
    repeat (10) begin @(negedge clk); seen_req |= mem_req_o; end
    check("t7_trap", {31'd0, trap_o}, 32'd1);
    check("t7_req_quiet", {31'd0, seen_req}, 32'd0);
    check("t7_retired", retired_o, 32'd0);
    check("t7_accesses", 32'(n_access), 32'd1);
    check("t7_ea", alu_result_o, SP_INIT + 32'd2);

    // reset pulsed while a fetch is stalled on ready
    enter_reset(3);
    put(0, enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    put(1, enc_i(6'h08, 5'd8, 5'd8, 16'd1));
    put(2, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    release_reset("t8", t0);
    wait_retired("t8_r2", 32'd2, t1);
    check("t8_pc_before", pc_o, RESET_PC + 32'h08);
    check("t8_req_waiting", {31'd0, mem_req_o}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t8_rst_req", {31'd0, mem_req_o}, 32'd0);
    check("t8_rst_we", {31'd0, mem_we_o}, 32'd0);
    check("t8_rst_pc", pc_o, RESET_PC);
    check("t8_rst_retired", retired_o, 32'd0);
    check("t8_rst_alu", alu_result_o, 32'd0);
    check("t8_rst_trap", {31'd0, trap_o}, 32'd0);
    check("t8_rst_state", {28'd0, state_o}, 32'd0);
    repeat (2) @(negedge clk);
    rd_log.delete();
    exp_q.push_back(RESET_PC);
    release_reset("t8_rel", t0);
    wait_retired("t8_again", 32'd1, t1);
    check("t8_alu_again", alu_result_o, 32'd1);
    check_fetches("t8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
